// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, a - b, one bit per clock, LSB first.
// Each bit uses the half-subtractor pair (a^b, ~a&b) plus a registered borrow-in.
// Result, borrow-out (and optional overflow) are published only at completion.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             bf;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // Full-subtractor bit from the current LSBs and the registered borrow.
    always_comb begin
        d        = sa[0] ^ sb[0] ^ bf;
        bnext    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
        res_next = {d, res[WIDTH-1:1]};
        // On the last bit sa[0]/sb[0] are the operand MSBs and d is the result MSB.
        ovf_next = (sa[0] ^ sb[0]) & (d ^ sa[0]);
    end

    // Control FSM and datapath; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        bf    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    bf  <= bnext;
                    res <= res_next;
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        Diff   <= res_next;
                        Borrow <= bnext;
`ifdef SERIAL_SUB_OVF_EN
                        Ovf    <= ovf_next;
`endif
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // The edge leaving DONE may accept a new operation, so a held
                    // start yields one op every WIDTH+1 cycles.
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        bf    <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed table plus hand sequences for serial_sub (WIDTH=8),
// and an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] last_diff = '0;
    logic       last_borrow = 1'b0;
    logic       last_ovf = 1'b0;

    serial_sub #(.WIDTH(8)) u8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .Diff   (diff8),
        .Borrow (borrow8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf    (ovf8)
`endif
    );

    serial_sub #(.WIDTH(4)) u4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .Diff   (diff4),
        .Borrow (borrow4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf    (ovf4)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic [3:0] p1;
        logic [3:0] p2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 op: accept on the next edge, optional start pulses sampled at
    // edges p1/p2 after accept, operands scrambled after accept.
    task automatic do_op(input string nm, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int p1, input int p2);
        int done_at;
        int ndone;
        int busy_n;
        a8 = va;
        b8 = vb;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'hFF;
        b8 = 8'h00;
        done_at = -1;
        ndone = 0;
        busy_n = busy8 ? 1 : 0;
        for (int i = 1; i <= 11; i++) begin
            start8 = (i == p1 || i == p2);
            @(posedge clk);
            #1;
            start8 = 1'b0;
            if (busy8) busy_n++;
            if (done8) begin
                ndone++;
                done_at = i;
                chk({nm, " diff"}, 32'(diff8), 32'(ed));
                chk({nm, " borrow"}, 32'(borrow8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
                chk({nm, " ovf"}, 32'(ovf8), 32'(eo));
`endif
            end else if (i < 8) begin
                chk({nm, " diff hold"}, 32'(diff8), 32'(last_diff));
            end
        end
        chk({nm, " done edge"}, 32'(done_at), 32'd8);
        chk({nm, " done count"}, 32'(ndone), 32'd1);
        chk({nm, " busy cycles"}, 32'(busy_n), 32'd9);
        chk({nm, " idle after"}, 32'(busy8), 32'd0);
        chk({nm, " diff held"}, 32'(diff8), 32'(ed));
        last_diff = ed;
        last_borrow = eb;
        last_ovf = eo;
    endtask

    initial begin
        int first_at;
        int second_at;
        int nd;
        logic [4:0] exp5;

        vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0, p1: 4'd0, p2: 4'd0};
        vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0, p1: 4'd0, p2: 4'd0};
        vecs[2] = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0, ov: 1'b0, p1: 4'd0, p2: 4'd0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0, p1: 4'd0, p2: 4'd0};
        vecs[4] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0, p1: 4'd0, p2: 4'd0};
        vecs[5] = '{a: 8'h12, b: 8'h34, d: 8'hDE, bo: 1'b1, ov: 1'b0, p1: 4'd3, p2: 4'd8};
        vecs[6] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1, p1: 4'd0, p2: 4'd0};
        vecs[7] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1, p1: 4'd0, p2: 4'd0};

        // Reset state.
        #12;
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset diff", 32'(diff8), 32'd0);
        chk("reset borrow", 32'(borrow8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset ovf", 32'(ovf8), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back: start held high, operands changed after the first accept.
        a8 = 8'h03;
        b8 = 8'h05;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h00;
        b8 = 8'h00;
        first_at = -1;
        second_at = -1;
        nd = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) start8 = 1'b0;
            if (done8) begin
                nd++;
                if (nd == 1) begin
                    first_at = i;
                    chk("b2b op1 diff", 32'(diff8), 32'h0FE);
                    chk("b2b op1 borrow", 32'(borrow8), 32'd1);
                end else begin
                    second_at = i;
                    chk("b2b op2 diff", 32'(diff8), 32'h000);
                    chk("b2b op2 borrow", 32'(borrow8), 32'd0);
                end
            end
        end
        chk("b2b done count", 32'(nd), 32'd2);
        chk("b2b first done edge", 32'(first_at), 32'd8);
        chk("b2b second done edge", 32'(second_at), 32'd17);
        chk("b2b idle after", 32'(busy8), 32'd0);
        last_diff = 8'h00;

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            do_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].bo,
                  vecs[v].ov, int'(vecs[v].p1), int'(vecs[v].p2));
        end

        // Reset mid-operation: asserted between edges, outputs must clear at once.
        a8 = 8'hAA;
        b8 = 8'h55;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        nd = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (done8) nd++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort diff", 32'(diff8), 32'd0);
        chk("abort borrow", 32'(borrow8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort ovf", 32'(ovf8), 32'd0);
`endif
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (done8) nd++;
        end
        rst = 1'b0;
        chk("abort no done", 32'(nd), 32'd0);
        last_diff = 8'h00;
        do_op("recover", 8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 0, 0);

        // Exhaustive WIDTH=4 sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a4 = 4'(ia);
                b4 = 4'(ib);
                start4 = 1'b1;
                @(posedge clk);
                #1;
                start4 = 1'b0;
                exp5 = 5'((ia - ib) & 31);
                nd = 0;
                for (int i = 1; i <= 6; i++) begin
                    @(posedge clk);
                    #1;
                    if (done4) begin
                        nd++;
                        chk($sformatf("w4 %0d-%0d", ia, ib), 32'({borrow4, diff4}),
                            32'(exp5));
                    end
                end
                chk($sformatf("w4 %0d-%0d done count", ia, ib), 32'(nd), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
